// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment controller: FSM states,
// the per-digit record and the blank pattern.
package seg_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  typedef struct packed {
    logic [3:0] data;
    logic       en;
    logic       blink;
  } digit_t;

endpackage : seg_pkg

// File: rtl/seg_ctrl_hex7seg.sv
// Hex digit to seven-segment decoder; active-low, bit0 = a ... bit6 = g.
module hex7seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    case (hex_i)
      4'h0:    seg_n_o = 7'h40;
      4'h1:    seg_n_o = 7'h79;
      4'h2:    seg_n_o = 7'h24;
      4'h3:    seg_n_o = 7'h30;
      4'h4:    seg_n_o = 7'h19;
      4'h5:    seg_n_o = 7'h12;
      4'h6:    seg_n_o = 7'h02;
      4'h7:    seg_n_o = 7'h78;
      4'h8:    seg_n_o = 7'h00;
      4'h9:    seg_n_o = 7'h10;
      4'hA:    seg_n_o = 7'h08;
      4'hB:    seg_n_o = 7'h03;
      4'hC:    seg_n_o = 7'h46;
      4'hD:    seg_n_o = 7'h21;
      4'hE:    seg_n_o = 7'h06;
      default: seg_n_o = 7'h0E;
    endcase
  end

endmodule : hex7seg

// File: rtl/seg_ctrl.sv
// Two-port round-robin writer for eight hex digits with a clear sweep.
// Optional blinking is compiled in when SEG_CTRL_BLINK_EN is defined.
module seg_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [2:0] a_idx,
  input  logic [3:0] a_data,
  input  logic       a_en,
  input  logic       a_blink,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [2:0] b_idx,
  input  logic [3:0] b_data,
  input  logic       b_en,
  input  logic       b_blink,
  input  logic       clr,
  output logic       busy,
  output logic [7:0] seg0,
  output logic [7:0] seg1,
  output logic [7:0] seg2,
  output logic [7:0] seg3,
  output logic [7:0] seg4,
  output logic [7:0] seg5,
  output logic [7:0] seg6,
  output logic [7:0] seg7
);

  if (BLINK_DIV < 2) begin : g_bad_blink_div
    $error("seg_ctrl: BLINK_DIV must be at least 2");
  end

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       fav_b_q, fav_b_d;  // 1: port B wins the next contested cycle
  digit_t     digits_q [NUM_DIGITS];
  digit_t     digits_d [NUM_DIGITS];

  logic grant_b, can_accept, a_fire, b_fire;

  always_comb begin
    grant_b = fav_b_q;
    if (a_valid && !b_valid)      grant_b = 1'b0;
    else if (b_valid && !a_valid) grant_b = 1'b1;
  end

  assign can_accept = (state_q == IDLE) && !clr;
  assign a_ready    = can_accept && !grant_b;
  assign b_ready    = can_accept && grant_b;
  assign a_fire     = a_valid && a_ready;
  assign b_fire     = b_valid && b_ready;
  assign busy       = (state_q == CLEAR);

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fav_b_d  = fav_b_q;
    digits_d = digits_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = 3'd0;
        end else if (a_fire) begin
          digits_d[a_idx] = '{data: a_data, en: a_en, blink: a_blink};
          fav_b_d         = 1'b1;
        end else if (b_fire) begin
          digits_d[b_idx] = '{data: b_data, en: b_en, blink: b_blink};
          fav_b_d         = 1'b0;
        end
      end
      CLEAR: begin
        digits_d[cnt_q] = '0;
        cnt_d           = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      fav_b_q <= 1'b0;
      // NOTE: the digit file is tiny and must power up blank, so it is reset like plain flops.
      for (int i = 0; i < NUM_DIGITS; i++) digits_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fav_b_q  <= fav_b_d;
      digits_q <= digits_d;
    end
  end

  logic [NUM_DIGITS-1:0] blink_hide;

`ifdef SEG_CTRL_BLINK_EN
  localparam int unsigned DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [DIV_W-1:0] blink_cnt_q;
  logic             phase_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == DIV_W'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + DIV_W'(1);
    end
  end

  always_comb begin
    blink_hide = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      blink_hide[i] = digits_q[i].en && digits_q[i].blink && phase_q;
    end
  end
`else
  logic [NUM_DIGITS-1:0] blink_bits;
  logic                  unused_blink;

  always_comb begin
    blink_bits = '0;
    for (int i = 0; i < NUM_DIGITS; i++) blink_bits[i] = digits_q[i].blink;
  end

  assign unused_blink = ^blink_bits;
  assign blink_hide   = '0;
`endif

  logic [7:0] seg_arr [NUM_DIGITS];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [6:0] hex_seg;

    hex7seg u_hex7seg (
      .hex_i   (digits_q[i].data),
      .seg_n_o (hex_seg)
    );

    assign seg_arr[i] = (!digits_q[i].en || blink_hide[i]) ? SEG_BLANK : {1'b1, hex_seg};
  end

  assign seg0 = seg_arr[0];
  assign seg1 = seg_arr[1];
  assign seg2 = seg_arr[2];
  assign seg3 = seg_arr[3];
  assign seg4 = seg_arr[4];
  assign seg5 = seg_arr[5];
  assign seg6 = seg_arr[6];
  assign seg7 = seg_arr[7];

endmodule : seg_ctrl

// File: tb/tb_seg_ctrl.sv
// Directed bench for seg_ctrl: reset, arbitration, writes, clear sweep,
// blink (either build of SEG_CTRL_BLINK_EN) and reset during a sweep.
module tb_seg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, b_valid, a_en, b_en, a_blink, b_blink, clr;
  logic [2:0] a_idx, b_idx;
  logic [3:0] a_data, b_data;
  logic       a_ready, b_ready, busy;
  logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
  logic [7:0] seg [8];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg_ctrl #(.BLINK_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_idx   (a_idx),
    .a_data  (a_data),
    .a_en    (a_en),
    .a_blink (a_blink),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_idx   (b_idx),
    .b_data  (b_data),
    .b_en    (b_en),
    .b_blink (b_blink),
    .clr     (clr),
    .busy    (busy),
    .seg0    (seg0),
    .seg1    (seg1),
    .seg2    (seg2),
    .seg3    (seg3),
    .seg4    (seg4),
    .seg5    (seg5),
    .seg6    (seg6),
    .seg7    (seg7)
  );

  assign seg[0] = seg0;
  assign seg[1] = seg1;
  assign seg[2] = seg2;
  assign seg[3] = seg3;
  assign seg[4] = seg4;
  assign seg[5] = seg5;
  assign seg[6] = seg6;
  assign seg[7] = seg7;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] first, cur, other;
    logic       seen;

    rst = 1'b1;
    {a_valid, b_valid, a_en, b_en, a_blink, b_blink, clr} = '0;
    a_idx = '0; b_idx = '0; a_data = '0; b_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    for (int i = 0; i < 8; i++) check($sformatf("rst_seg%0d", i), seg[i], 8'hFF);
    check("rst_busy", busy, 1'b0);
    check("rst_a_ready", a_ready, 1'b1);
    check("rst_b_ready", b_ready, 1'b0);

    // Lone B request is granted combinationally
    tick();
    b_valid = 1'b1;
    #1;
    check("lone_b_ready", b_ready, 1'b1);
    check("lone_b_a_ready", a_ready, 1'b0);
    b_valid = 1'b0;

    // Contested: A first after reset, then B
    a_valid = 1'b1; a_idx = 3'd1; a_data = 4'h1; a_en = 1'b1;
    b_valid = 1'b1; b_idx = 3'd2; b_data = 4'hA; b_en = 1'b1;
    #1;
    check("rr1_a_ready", a_ready, 1'b1);
    check("rr1_b_ready", b_ready, 1'b0);
    tick();
    check("rr2_a_ready", a_ready, 1'b0);
    check("rr2_b_ready", b_ready, 1'b1);
    check("rr1_seg1", seg1, 8'hF9);
    check("rr1_seg2", seg2, 8'hFF);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    check("rr_seg1", seg1, 8'hF9);
    check("rr_seg2", seg2, 8'h88);

    // Single A write to digit 0
    tick();
    a_valid = 1'b1; a_idx = 3'd0; a_data = 4'h0; a_en = 1'b1; a_blink = 1'b0;
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    check("wr_seg0", seg0, 8'hC0);
    check("wr_seg3", seg3, 8'hFF);

    // Fill all digits with 8
    tick();
    for (int i = 0; i < 8; i++) begin
      a_valid = 1'b1; a_idx = 3'(i); a_data = 4'h8; a_en = 1'b1;
      tick();
    end
    a_valid = 1'b0;
    @(negedge clk);
    check("fill_seg0", seg0, 8'h80);
    check("fill_seg7", seg7, 8'h80);

    // Clear sweep with a_valid held (will write 5 to digit 0 afterwards)
    tick();
    clr = 1'b1; a_valid = 1'b1; a_idx = 3'd0; a_data = 4'h5; a_en = 1'b1;
    #1;
    check("clr_wins_a_ready", a_ready, 1'b0);
    tick();
    clr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("sweep%0d_busy", k), busy, 1'b1);
      check($sformatf("sweep%0d_a_ready", k), a_ready, 1'b0);
      check($sformatf("sweep%0d_seg_pending", k), seg[k], 8'h80);
      if (k > 0) check($sformatf("sweep%0d_seg_blank", k), seg[k-1], 8'hFF);
      tick();
    end
    @(negedge clk);
    check("sweep_done_busy", busy, 1'b0);
    check("sweep_done_a_ready", a_ready, 1'b1);
    check("sweep_done_seg7", seg7, 8'hFF);
    check("sweep_done_seg0", seg0, 8'hFF);
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    check("post_sweep_seg0", seg0, 8'h92);

    // Blink digit 3 = F
    tick();
    a_valid = 1'b1; a_idx = 3'd3; a_data = 4'hF; a_en = 1'b1; a_blink = 1'b1;
    tick();
    a_valid = 1'b0; a_blink = 1'b0;
`ifdef SEG_CTRL_BLINK_EN
    @(negedge clk);
    first = seg3;
    seen  = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (seg3 != first) seen = 1'b1;
    end
    check("blink_toggle_seen", seen, 1'b1);
    cur   = seg3;
    other = (cur == 8'h8E) ? 8'hFF : 8'h8E;
    check("blink_level", (cur == 8'h8E) || (cur == 8'hFF), 1'b1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("blink_hold%0d", k), seg3, cur);
    end
    @(negedge clk);
    check("blink_flip", seg3, other);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("blink_hold2_%0d", k), seg3, other);
    end
`else
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("steady%0d_seg3", k), seg3, 8'h8E);
    end
`endif

    // Reset during sweep cycle 3, then contested grant goes to A
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (3) tick();
    check("mid_sweep_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", busy, 1'b0);
    for (int i = 0; i < 8; i++) check($sformatf("rst_mid_seg%0d", i), seg[i], 8'hFF);
    tick();
    rst = 1'b0;
    a_valid = 1'b1; a_idx = 3'd4; a_data = 4'h1; a_en = 1'b1;
    b_valid = 1'b1; b_idx = 3'd5; b_data = 4'h2; b_en = 1'b1;
    #1;
    check("post_rst_a_ready", a_ready, 1'b1);
    check("post_rst_b_ready", b_ready, 1'b0);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    check("post_rst_seg4", seg4, 8'hF9);
    check("post_rst_seg5", seg5, 8'hFF);
    check("post_rst_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_seg_ctrl

// File: doc/seg_ctrl.md
# seg_ctrl

Arbitrated controller for the board's eight seven-segment digits. Two independent requesters, the PS/2 key path and the switch/encoder path, write 4-bit hex values into per-digit registers over valid/ready handshakes, with round-robin arbitration. The block owns the digit registers and the decode, and drives seg0..seg7 directly. A clear command runs an 8-cycle sweep that blanks every digit.

## Interface
- BLINK_DIV, default 5000000: cycles per blink half-period; must be ≥ 2.
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- a_valid  in  1  port A write request (PS/2 path)
- a_ready  out  1  port A grant; transfer when a_valid & a_ready
- a_idx  in  3  target digit, 0..7
- a_data  in  4  hex value
- a_en  in  1  digit enable written with the data; 0 blanks the digit
- a_blink  in  1  digit blink flag
- b_valid, b_ready, b_idx, b_data, b_en, b_blink: port B (switch/encoder path), same widths and meanings as port A
- clr  in  1  single-cycle clear request
- busy  out  1  high while the clear sweep runs
- seg0..seg7  out  8 each  active-low segments; bit0 = a … bit6 = g, bit7 = DP (always 1)

## Operation
- Per-digit state: data[3:0], en, blink. All reset to 0.
- FSM states:
  - IDLE: accepts writes. clr → CLEAR with sweep counter = 0.
  - CLEAR: clears digit[cnt] (data, en, blink all 0) each cycle. cnt 0→7; after clearing digit 7 → IDLE.
- clr is ignored in CLEAR; the sweep is not restarted.
- Ready rule: a_ready/b_ready = (state == IDLE) & !clr & grant.
  - Exactly one port is granted per cycle.
  - Only one valid: that port is granted.
  - Both valid: grant goes to the port not favoured by the last accepted transfer. The rr pointer resets to favour A.
  - Neither valid: ready is still driven for the favoured port (A after reset). This lets valid see ready combinationally.
- The rr pointer updates only on an accepted transfer.
- Accepted transfer writes {data, en, blink} to digit[idx] at the clock edge.
- Only one write per cycle, so same-idx collisions cannot occur.
- clr and valid in the same IDLE cycle: clr wins and no transfer occurs.
- Output decode is combinational from the registers:
  - en = 0 → 8'hFF.
  - en = 1 → {1'b1, hex7seg(data)}.
  - Examples: 0 = C0, 1 = F9, 8 = 80, A = 88, F = 8E.
- busy = (state == CLEAR).

## Timing
- Reset values: seg0..7 = 8'hFF, busy = 0, state IDLE, rr favours A, blink counter and phase = 0.
- Ready outputs after reset: a_ready = a_valid | !b_valid; b_ready = b_valid & !a_valid.
- Write latency: handshake at edge N → segment output reflects new value after edge N, one cycle.
- Back-to-back transfers from both ports alternate every cycle, A first after reset.
- Clear timing: clr sampled at edge N → busy high from N through N+8.
  - Digit i is blank after edge N+1+i.
  - Ready is low for those 8 cycles.
  - IDLE and ready are restored after edge N+8.
- Reset asserted mid-sweep: immediate return to reset values; a partial sweep is not resumed.
- Ready is combinational from valid/clr/state/rr. Valid must not depend combinationally on ready.

## Configuration
- SEG_CTRL_BLINK_EN defined:
  - A counter runs 0..BLINK_DIV-1 and toggles the blink phase on wrap.
  - An enabled digit with blink = 1 outputs 8'hFF while phase = 1.
  - The counter keeps running through CLEAR and is reset only by rst.
- Undefined:
  - No counter or phase register.
  - Blink bits are still stored but ignored; enabled digits are steady.
  - BLINK_DIV is unused.

## Structure
- Package seg_pkg holds:
  - the FSM state enum {IDLE, CLEAR};
  - SEG_BLANK = 8'hFF;
  - NUM_DIGITS = 8;
  - the digit-record typedef {data, en, blink}.
- Sub-module hex7seg: 4-bit in, 7-bit active-low out. Instantiated 8 times.

## Test plan
- Reset released, no valids → all seg = FF, busy = 0, a_ready = 1, b_ready = 0.
- A writes idx0 data 0 en 1 → seg0 = C0 next cycle; other digits remain FF.
- Both ports valid for 2 cycles: A (idx1, 1, en 1) and B (idx2, A, en 1) → cycle 1 grants A, cycle 2 grants B; seg1 = F9, seg2 = 88.
- Fill all digits with 8, then pulse clr with a_valid held:
  - busy is high for 8 cycles and a_ready is 0;
  - seg_i becomes FF one per cycle;
  - a_ready returns after the sweep.
- Blink test with BLINK_DIV = 4 and digit3 = F, en 1, blink 1:
  - with SEG_CTRL_BLINK_EN, seg3 alternates 8E/FF every 4 cycles;
  - without the macro, seg3 holds 8E.
- Assert rst at cycle 3 of a clear sweep → all seg FF and busy 0 immediately; the next contested grant goes to A.
